puck_ctl: RTL and testbench

Per-frame game controller for the air-hockey table. Once per video frame, at the start of vertical blanking, it advances the puck position and resolves wall bounces, mallet hits and goals. It also keeps both scores and sequences the game through idle, serve, play, goal and game-over phases. It sits beside the VGA timing/draw pipeline on the pixel clock domain and feeds the puck and score drawing stages, whose outputs stay stable for the whole active frame.

---
 rtl/puck_ctl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_puck_ctl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puck_ctl.sv
// puck_ctl: per-frame air-hockey game controller.
// Advances the puck once per vertical blank (STEP -> RESOLVE -> COMMIT),
// resolves goals, wall bounces and mallet hits, keeps the scores and
// sequences idle/serve/play/goal/game-over. All outputs are registered and
// only change during the short update sequence after a vblank rising edge.
module puck_ctl #(
    parameter int H_RES        = 1024,
    parameter int V_RES        = 768,
    parameter int PUCK_R       = 16,
    parameter int MALLET_R     = 24,
    parameter int GOAL_Y_MIN   = 284,
    parameter int GOAL_Y_MAX   = 484,
    parameter int SPEED        = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [11:0] mallet_l_x,
    input  logic [11:0] mallet_l_y,
    input  logic [11:0] mallet_r_x,
    input  logic [11:0] mallet_r_y,
    output logic [11:0] puck_x,
    output logic [11:0] puck_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        goal_l,
    output logic        goal_r,
    output logic        game_over
);

    localparam logic [11:0]        CX         = 12'(H_RES / 2);
    localparam logic [11:0]        CY         = 12'(V_RES / 2);
    localparam logic signed [12:0] X_MIN      = 13'(PUCK_R);
    localparam logic signed [12:0] X_MAX      = 13'(H_RES - 1 - PUCK_R);
    localparam logic signed [12:0] Y_MIN      = 13'(PUCK_R);
    localparam logic signed [12:0] Y_MAX      = 13'(V_RES - 1 - PUCK_R);
    localparam logic signed [12:0] GY_MIN     = 13'(GOAL_Y_MIN);
    localparam logic signed [12:0] GY_MAX     = 13'(GOAL_Y_MAX);
    localparam logic signed [13:0] HIT_R      = 14'(PUCK_R + MALLET_R);
    localparam logic signed [5:0]  SPD        = 6'(SPEED);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SERVE   = 3'd1,
        S_PLAY    = 3'd2,
        S_RESOLVE = 3'd3,
        S_COMMIT  = 3'd4,
        S_GOAL    = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    // Magnitude of a signed mallet distance.
    function automatic logic signed [13:0] abs14(input logic signed [13:0] v);
        abs14 = v[13] ? -v : v;
    endfunction

    // Velocity component pointing along the sign of v (zero when v is zero).
    function automatic logic signed [5:0] dir_of(input logic signed [13:0] v);
        if (v > 14'sd0) begin
            dir_of = SPD;
        end else if (v < 14'sd0) begin
            dir_of = -SPD;
        end else begin
            dir_of = 6'sd0;
        end
    endfunction

    state_t             state_q, state_d;
    logic               vblnk_q, vblnk_d, vblnk_dd_q, vblnk_dd_d;
    logic [11:0]        puck_x_q, puck_x_d, puck_y_q, puck_y_d;
    logic signed [5:0]  vx_q, vx_d, vy_q, vy_d;
    logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
    logic               goal_l_q, goal_l_d, goal_r_q, goal_r_d;
    logic               game_over_q, game_over_d;
    logic [15:0]        serve_cnt_q, serve_cnt_d;
    logic               serve_neg_q, serve_neg_d;
    logic signed [12:0] nx_q, nx_d, ny_q, ny_d;
    logic [11:0]        rx_q, rx_d, ry_q, ry_d;
    logic signed [5:0]  rvx_q, rvx_d, rvy_q, rvy_d;
    logic               rgl_q, rgl_d, rgr_q, rgr_d;

    logic               tick_s, mouth_s, goal_l_s, goal_r_s, hit_l_s, hit_r_s;
    logic signed [12:0] wx_s, wy_s;
    logic signed [5:0]  wvx_s, wvy_s, fvx_s, fvy_s;
    logic signed [13:0] dxl_s, dyl_s, dxr_s, dyr_s;

    // Rising edge of the registered vertical blank.
    assign tick_s = vblnk_q & ~vblnk_dd_q;

    // Resolve the stepped position: goal window, wall clamps, then mallet hits.
    always_comb begin
        mouth_s  = (ny_q >= GY_MIN) && (ny_q <= GY_MAX);
        goal_r_s = mouth_s && (nx_q < X_MIN);
        goal_l_s = mouth_s && (nx_q > X_MAX);
        if (nx_q < X_MIN) begin
            wx_s  = X_MIN;
            wvx_s = -vx_q;
        end else if (nx_q > X_MAX) begin
            wx_s  = X_MAX;
            wvx_s = -vx_q;
        end else begin
            wx_s  = nx_q;
            wvx_s = vx_q;
        end
        if (ny_q < Y_MIN) begin
            wy_s  = Y_MIN;
            wvy_s = -vy_q;
        end else if (ny_q > Y_MAX) begin
            wy_s  = Y_MAX;
            wvy_s = -vy_q;
        end else begin
            wy_s  = ny_q;
            wvy_s = vy_q;
        end
        dxl_s   = $signed({wx_s[12], wx_s}) - $signed({2'b00, mallet_l_x});
        dyl_s   = $signed({wy_s[12], wy_s}) - $signed({2'b00, mallet_l_y});
        dxr_s   = $signed({wx_s[12], wx_s}) - $signed({2'b00, mallet_r_x});
        dyr_s   = $signed({wy_s[12], wy_s}) - $signed({2'b00, mallet_r_y});
        hit_l_s = (abs14(dxl_s) <= HIT_R) && (abs14(dyl_s) <= HIT_R);
        hit_r_s = (abs14(dxr_s) <= HIT_R) && (abs14(dyr_s) <= HIT_R);
        // A goal outranks everything; the left mallet outranks the right one.
        if (goal_l_s || goal_r_s) begin
            fvx_s = 6'sd0;
            fvy_s = 6'sd0;
        end else if (hit_l_s) begin
            fvx_s = (dxl_s >= 14'sd0) ? SPD : -SPD;
            fvy_s = dir_of(dyl_s);
        end else if (hit_r_s) begin
            fvx_s = (dxr_s >= 14'sd0) ? SPD : -SPD;
            fvy_s = dir_of(dyr_s);
        end else begin
            fvx_s = wvx_s;
            fvy_s = wvy_s;
        end
    end

    // Next-state logic for the game sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        vblnk_d     = vblnk_in;
        vblnk_dd_d  = vblnk_q;
        puck_x_d    = puck_x_q;
        puck_y_d    = puck_y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        goal_l_d    = 1'b0;
        goal_r_d    = 1'b0;
        game_over_d = game_over_q;
        serve_cnt_d = serve_cnt_q;
        serve_neg_d = serve_neg_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        rvx_d       = rvx_q;
        rvy_d       = rvy_q;
        rgl_d       = rgl_q;
        rgr_d       = rgr_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d     = S_SERVE;
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    serve_cnt_d = 16'd0;
                    serve_neg_d = 1'b0;
                    game_over_d = 1'b0;
                    puck_x_d    = CX;
                    puck_y_d    = CY;
                    vx_d        = 6'sd0;
                    vy_d        = 6'sd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SERVE: begin
                if (tick_s && (serve_cnt_q == SERVE_LAST)) begin
                    state_d     = S_PLAY;
                    serve_cnt_d = 16'd0;
                    vx_d        = serve_neg_q ? -SPD : SPD;
                    vy_d        = 6'sd1;
                end else if (tick_s) begin
                    serve_cnt_d = serve_cnt_q + 16'd1;
                end else begin
                    serve_cnt_d = serve_cnt_q;
                end
            end
            S_PLAY: begin
                if (tick_s) begin
                    state_d = S_RESOLVE;
                    nx_d    = $signed({1'b0, puck_x_q}) + $signed({{7{vx_q[5]}}, vx_q});
                    ny_d    = $signed({1'b0, puck_y_q}) + $signed({{7{vy_q[5]}}, vy_q});
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_RESOLVE: begin
                state_d = S_COMMIT;
                rx_d    = wx_s[11:0];
                ry_d    = wy_s[11:0];
                rvx_d   = fvx_s;
                rvy_d   = fvy_s;
                rgl_d   = goal_l_s;
                rgr_d   = goal_r_s;
            end
            S_COMMIT: begin
                if (rgl_q || rgr_q) begin
                    state_d     = S_GOAL;
                    score_l_d   = rgl_q ? score_l_q + 4'd1 : score_l_q;
                    score_r_d   = rgr_q ? score_r_q + 4'd1 : score_r_q;
                    goal_l_d    = rgl_q;
                    goal_r_d    = rgr_q;
                    serve_neg_d = rgr_q;
                    puck_x_d    = CX;
                    puck_y_d    = CY;
                    vx_d        = 6'sd0;
                    vy_d        = 6'sd0;
                end else begin
                    state_d  = S_PLAY;
                    puck_x_d = rx_q;
                    puck_y_d = ry_q;
                    vx_d     = rvx_q;
                    vy_d     = rvy_q;
                end
            end
            S_GOAL: begin
                if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                    state_d     = S_OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d     = S_SERVE;
                    serve_cnt_d = 16'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vblnk_q     <= 1'b0;
            vblnk_dd_q  <= 1'b0;
            puck_x_q    <= CX;
            puck_y_q    <= CY;
            vx_q        <= 6'sd0;
            vy_q        <= 6'sd0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            goal_l_q    <= 1'b0;
            goal_r_q    <= 1'b0;
            game_over_q <= 1'b0;
            serve_cnt_q <= 16'd0;
            serve_neg_q <= 1'b0;
            nx_q        <= 13'sd0;
            ny_q        <= 13'sd0;
            rx_q        <= 12'd0;
            ry_q        <= 12'd0;
            rvx_q       <= 6'sd0;
            rvy_q       <= 6'sd0;
            rgl_q       <= 1'b0;
            rgr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vblnk_q     <= vblnk_d;
            vblnk_dd_q  <= vblnk_dd_d;
            puck_x_q    <= puck_x_d;
            puck_y_q    <= puck_y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            goal_l_q    <= goal_l_d;
            goal_r_q    <= goal_r_d;
            game_over_q <= game_over_d;
            serve_cnt_q <= serve_cnt_d;
            serve_neg_q <= serve_neg_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            rvx_q       <= rvx_d;
            rvy_q       <= rvy_d;
            rgl_q       <= rgl_d;
            rgr_q       <= rgr_d;
        end
    end

    assign puck_x    = puck_x_q;
    assign puck_y    = puck_y_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign goal_l    = goal_l_q;
    assign goal_r    = goal_r_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_puck_ctl.sv
// tb_puck_ctl: randomized bench for puck_ctl. A frame-level game model
// predicts the state after each frame / start / reset; expectations are
// queued at issue time and a monitor compares them at each frame_end strobe.
module tb_puck_ctl;

    localparam int H_RES        = 1024;
    localparam int V_RES        = 768;
    localparam int PUCK_R       = 16;
    localparam int MALLET_R     = 24;
    localparam int GOAL_Y_MIN   = 284;
    localparam int GOAL_Y_MAX   = 484;
    localparam int SPEED        = 4;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 7;
    localparam int HIT          = PUCK_R + MALLET_R;
    localparam logic [11:0] FAR = 12'd4000;

    logic        clk_in = 1'b0;
    logic        rst, vblnk_in, start, frame_end;
    logic [11:0] ml_x, ml_y, mr_x, mr_y;
    logic [11:0] puck_x, puck_y;
    logic [3:0]  score_l, score_r;
    logic        goal_l, goal_r, game_over;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int px; int py; int sl; int sr; int go; int gl; int gr;
    } exp_t;
    exp_t exp_q[$];

    // model: phase 0 idle, 1 serve, 2 play, 3 over
    int m_phase, m_px, m_py, m_vx, m_vy, m_sl, m_sr, m_cnt, m_dir, m_gl, m_gr;
    int games_over = 0;
    bit rally_left = 1'b1;

    always #5 clk_in = ~clk_in;

    puck_ctl #(
        .H_RES(H_RES), .V_RES(V_RES), .PUCK_R(PUCK_R), .MALLET_R(MALLET_R),
        .GOAL_Y_MIN(GOAL_Y_MIN), .GOAL_Y_MAX(GOAL_Y_MAX), .SPEED(SPEED),
        .SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk_in(clk_in), .rst(rst), .vblnk_in(vblnk_in), .start(start),
        .mallet_l_x(ml_x), .mallet_l_y(ml_y), .mallet_r_x(mr_x), .mallet_r_y(mr_y),
        .puck_x(puck_x), .puck_y(puck_y), .score_l(score_l), .score_r(score_r),
        .goal_l(goal_l), .goal_r(goal_r), .game_over(game_over)
    );

    function automatic void check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sgn(int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic centre_puck();
        m_px = H_RES / 2; m_py = V_RES / 2; m_vx = 0; m_vy = 0;
    endtask

    task automatic model_reset();
        m_phase = 0; m_sl = 0; m_sr = 0; m_cnt = 0; m_dir = 1; m_gl = 0; m_gr = 0;
        centre_puck();
    endtask

    task automatic model_start();
        if (m_phase == 0 || m_phase == 3) begin
            m_phase = 1; m_sl = 0; m_sr = 0; m_cnt = 0; m_dir = 1;
            centre_puck();
        end
    endtask

    task automatic score_goal(bit left);
        int sc;
        if (left) begin m_sl++; m_gl++; m_dir = 1;  sc = m_sl; end
        else      begin m_sr++; m_gr++; m_dir = -1; sc = m_sr; end
        centre_puck();
        if (sc == WIN_SCORE) begin m_phase = 3; games_over++; end
        else begin m_phase = 1; m_cnt = 0; end
    endtask

    // One frame of game rules applied to the model.
    task automatic model_tick();
        int nx, ny, dxl, dyl, dxr, dyr;
        bit mouth;
        if (m_phase == 1) begin
            m_cnt++;
            if (m_cnt == SERVE_FRAMES) begin
                m_phase = 2; m_cnt = 0; m_vx = m_dir * SPEED; m_vy = 1;
            end
        end else if (m_phase == 2) begin
            nx = m_px + m_vx;
            ny = m_py + m_vy;
            mouth = (ny >= GOAL_Y_MIN) && (ny <= GOAL_Y_MAX);
            if (mouth && nx < PUCK_R) score_goal(1'b0);
            else if (mouth && nx > H_RES - 1 - PUCK_R) score_goal(1'b1);
            else begin
                if (nx < PUCK_R) begin nx = PUCK_R; m_vx = -m_vx; end
                else if (nx > H_RES - 1 - PUCK_R) begin nx = H_RES - 1 - PUCK_R; m_vx = -m_vx; end
                if (ny < PUCK_R) begin ny = PUCK_R; m_vy = -m_vy; end
                else if (ny > V_RES - 1 - PUCK_R) begin ny = V_RES - 1 - PUCK_R; m_vy = -m_vy; end
                dxl = nx - int'(ml_x); dyl = ny - int'(ml_y);
                dxr = nx - int'(mr_x); dyr = ny - int'(mr_y);
                if (iabs(dxl) <= HIT && iabs(dyl) <= HIT) begin
                    m_vx = (dxl >= 0) ? SPEED : -SPEED; m_vy = sgn(dyl) * SPEED;
                end else if (iabs(dxr) <= HIT && iabs(dyr) <= HIT) begin
                    m_vx = (dxr >= 0) ? SPEED : -SPEED; m_vy = sgn(dyr) * SPEED;
                end
                m_px = nx; m_py = ny;
            end
        end
    endtask

    task automatic push_exp();
        exp_q.push_back('{m_px, m_py, m_sl, m_sr, int'(m_phase == 3), m_gl, m_gr});
        m_gl = 0; m_gr = 0;
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic strobe();
        frame_end = 1'b1;
        cyc(1);
        frame_end = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        model_start();
        push_exp();
        strobe();
    endtask

    // One vblank frame; optionally checks the exact update latency.
    task automatic frame(bit lat);
        int opx, opy;
        opx = m_px; opy = m_py;
        vblnk_in = 1'b1;
        cyc(1);
        model_tick();
        push_exp();
        cyc(1);
        vblnk_in = 1'b0;
        cyc(1);
        if (lat) begin
            check("lat_hold_x", int'(puck_x), opx);
            check("lat_hold_y", int'(puck_y), opy);
        end
        cyc(1);
        if (lat) begin
            check("lat_upd_x", int'(puck_x), m_px);
            check("lat_upd_y", int'(puck_y), m_py);
        end
        cyc(2);
        strobe();
    endtask

    // Reset arriving while an update sequence is in flight.
    task automatic rst_mid();
        vblnk_in = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rstmid_x", int'(puck_x), H_RES / 2);
        check("rstmid_y", int'(puck_y), V_RES / 2);
        check("rstmid_scores", int'({score_l, score_r}), 0);
        check("rstmid_go", int'(game_over), 0);
        vblnk_in = 1'b0;
        model_reset();
        push_exp();
        cyc(4);
        strobe();
    endtask

    task automatic far_mallets();
        ml_x = FAR; ml_y = FAR; mr_x = FAR; mr_y = FAR;
    endtask

    task automatic pick_mallets();
        int r, nx, ny, tx, ty;
        far_mallets();
        r = int'($urandom_range(0, 9));
        if (m_phase == 2 && r < 5) begin
            nx = m_px + m_vx;
            ny = m_py + m_vy;
            tx = rally_left ? nx + 30 : nx - 30;
            if (ny < GOAL_Y_MIN + 10) ty = ny - 10;
            else if (ny > GOAL_Y_MAX - 10) ty = ny + 10;
            else ty = ny;
            if ($urandom_range(0, 1) == 0) begin ml_x = 12'(tx); ml_y = 12'(ty); end
            else begin mr_x = 12'(tx); mr_y = 12'(ty); end
        end else if (m_phase == 2 && r < 7) begin
            ml_x = 12'(m_px + int'($urandom_range(0, 120)) - 60);
            ml_y = 12'(m_py + int'($urandom_range(0, 120)) - 60);
            mr_x = 12'(m_px + int'($urandom_range(0, 120)) - 60);
            mr_y = 12'(m_py + int'($urandom_range(0, 120)) - 60);
        end
    endtask

    // Monitor: counts goal pulse cycles and compares at each frame_end strobe.
    initial begin
        int gl_acc, gr_acc;
        exp_t e;
        gl_acc = 0; gr_acc = 0;
        forever begin
            @(negedge clk_in);
            gl_acc += int'(goal_l);
            gr_acc += int'(goal_r);
            if (frame_end) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard: got strobe expected queued entry");
                end else begin
                    e = exp_q.pop_front();
                    check("puck_x", int'(puck_x), e.px);
                    check("puck_y", int'(puck_y), e.py);
                    check("score_l", int'(score_l), e.sl);
                    check("score_r", int'(score_r), e.sr);
                    check("game_over", int'(game_over), e.go);
                    check("goal_l_cycles", gl_acc, e.gl);
                    check("goal_r_cycles", gr_acc, e.gr);
                end
                gl_acc = 0; gr_acc = 0;
            end
        end
    end

    // Stimulus: directed opening, then randomized play.
    initial begin
        rst = 1'b1; vblnk_in = 1'b0; start = 1'b0; frame_end = 1'b0;
        far_mallets();
        cyc(3);
        rst = 1'b0;
        model_reset();
        push_exp();
        strobe();
        do_start();
        for (int i = 0; i < SERVE_FRAMES; i++) frame(1'b0);
        frame(1'b1);
        for (int i = 0; i < 5; i++) frame(1'b0);
        rst_mid();
        do_start();
        for (int f = 0; f < 7000 && games_over < 2; f++) begin
            if (m_phase == 0) begin
                do_start();
            end else if (m_phase == 3) begin
                if ($urandom_range(0, 3) == 0) do_start();
                else begin far_mallets(); frame(1'b0); end
            end else begin
                if (m_phase == 2 && $urandom_range(0, 49) == 0) do_start();
                if (m_phase == 1) rally_left = ($urandom_range(0, 3) != 0);
                pick_mallets();
                frame($urandom_range(0, 15) == 0);
            end
        end
        check("games_completed", int'(games_over > 0), 1);
        cyc(2);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
